// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port burst-limited arbiter onto a single-port synchronous data memory.
module data_mem_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              freeze,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic              mem_debugaccess,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);
  logic       last_gnt;
  logic [3:0] burst_cnt;
  logic       rv0, rv1;
  logic       keep, sel, gnt;
  // burst_cnt==0 means no owner yet, so the first tie after reset goes to port 0
  always_comb begin
    keep            = burst_cnt != 4'd0 && burst_cnt < 4'(MAX_BURST);
    sel             = (p0_req & p1_req) ? (keep ? last_gnt : ~last_gnt) : p1_req;
    gnt             = reset_n & ~freeze & (p0_req | p1_req);
    p0_gnt          = gnt & ~sel;
    p1_gnt          = gnt & sel;
    mem_chipselect  = gnt;
    mem_address     = gnt ? (sel ? p1_addr : p0_addr) : '0;
    mem_writedata   = gnt ? (sel ? p1_wdata : p0_wdata) : '0;
    mem_write       = gnt & (sel ? p1_we : p0_we);
    mem_debugaccess = mem_write;
    mem_clken       = 1'b1;
    p0_rvalid       = rv0 & reset_n;
    p1_rvalid       = rv1 & reset_n;
    p0_rdata        = p0_rvalid ? mem_readdata : '0;
    p1_rdata        = p1_rvalid ? mem_readdata : '0;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_gnt  <= 1'b1;
      burst_cnt <= 4'd0;
      rv0       <= 1'b0;
      rv1       <= 1'b0;
    end else begin
      rv0 <= p0_gnt & ~p0_we;
      rv1 <= p1_gnt & ~p1_we;
      if (gnt) begin
        last_gnt  <= sel;
        burst_cnt <= sel != last_gnt ? 4'd1 : burst_cnt >= 4'(MAX_BURST) ? 4'(MAX_BURST) : burst_cnt + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed checks of arbitration, read latency, freeze and reset with a memory model.
module tb_data_mem_arbiter;
  logic       clk = 0, reset_n, freeze;
  logic       p0_req, p0_we, p1_req, p1_we;
  logic [9:0] p0_addr, p1_addr;
  logic [7:0] p0_wdata, p1_wdata;
  logic       p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [7:0] p0_rdata, p1_rdata;
  logic [9:0] mem_address;
  logic       mem_chipselect, mem_write, mem_debugaccess, mem_clken;
  logic [7:0] mem_writedata, mem_readdata;
  logic       q0_gnt, q0_rvalid, q1_gnt, q1_rvalid, q_cs, q_wr, q_dbg, q_clken;
  logic [7:0] q0_rdata, q1_rdata, q_wd;
  logic [9:0] q_addr;
  logic [7:0] mem [1024];
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  data_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n), .freeze(freeze),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_debugaccess(mem_debugaccess), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );
  data_mem_arbiter #(.MAX_BURST(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .freeze(freeze),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(q0_gnt), .p0_rvalid(q0_rvalid), .p0_rdata(q0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(q1_gnt), .p1_rvalid(q1_rvalid), .p1_rdata(q1_rdata),
    .mem_address(q_addr), .mem_chipselect(q_cs), .mem_write(q_wr),
    .mem_debugaccess(q_dbg), .mem_writedata(q_wd), .mem_clken(q_clken),
    .mem_readdata(8'h00)
  );
  initial for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
  always @(posedge clk) begin
    if (mem_chipselect & mem_write & mem_debugaccess) mem[mem_address] <= mem_writedata;
    mem_readdata <= mem[mem_address];
  end
  function automatic logic [7:0] f(input logic [9:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic r0, input logic w0, input logic [9:0] a0, input logic [7:0] d0,
                       input logic r1, input logic w1, input logic [9:0] a1, input logic [7:0] d1);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
  endtask
  task automatic next;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int e, pe;
    reset_n = 0; freeze = 0;
    drive(1, 0, 10'h010, 0, 1, 0, 10'h020, 0);
    repeat (2) begin
      @(negedge clk);
      check("rst_gnt", {p0_gnt, p1_gnt}, 0);
      check("rst_cs", mem_chipselect, 0);
      check("rst_rvalid", {p0_rvalid, p1_rvalid}, 0);
      check("rst_clken", mem_clken, 1);
      next;
    end
    reset_n = 1;
    pe = -1;
    for (int i = 0; i < 12; i++) begin
      e = (i / 4) % 2;
      @(negedge clk);
      check("burst_p0_gnt", p0_gnt, e == 0);
      check("burst_p1_gnt", p1_gnt, e == 1);
      check("burst_addr", mem_address, e ? 10'h020 : 10'h010);
      check("burst_cs", mem_chipselect, 1);
      check("alt_p0_gnt", q0_gnt, (i % 2) == 0);
      check("alt_p1_gnt", q1_gnt, (i % 2) == 1);
      check("burst_p0_rv", p0_rvalid, pe == 0);
      check("burst_p1_rv", p1_rvalid, pe == 1);
      if (pe >= 0) check("burst_rdata", pe ? p1_rdata : p0_rdata, pe ? f(10'h020) : f(10'h010));
      pe = e;
      next;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("burst_last_rv", {p0_rvalid, p1_rvalid}, 2'b10);
    check("idle_cs", mem_chipselect, 0);
    check("idle_addr", mem_address, 0);
    next;
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) drive(0, 0, 0, 0, 1, 0, 10'(i), 0);
      else drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("solo_p1_gnt", p1_gnt, i < 10);
      check("solo_p0_gnt", p0_gnt, 0);
      check("solo_p0_rv", p0_rvalid, 0);
      check("solo_p0_rdata", p0_rdata, 0);
      check("solo_p1_rv", p1_rvalid, i > 0);
      check("solo_p1_rdata", p1_rdata, i > 0 ? f(10'(i - 1)) : 8'h00);
      next;
    end
    drive(1, 1, 10'h3FF, 8'hA5, 0, 0, 0, 0);
    @(negedge clk);
    check("wr_gnt", p0_gnt, 1);
    check("wr_dbg", mem_debugaccess, 1);
    check("wr_write", mem_write, 1);
    check("wr_addr", mem_address, 10'h3FF);
    check("wr_wdata", mem_writedata, 8'hA5);
    next;
    drive(0, 0, 0, 0, 1, 0, 10'h3FF, 0);
    @(negedge clk);
    check("raw_p1_gnt", p1_gnt, 1);
    check("raw_dbg", mem_debugaccess, 0);
    check("raw_wr_no_rv", p0_rvalid, 0);
    next;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("raw_p1_rv", p1_rvalid, 1);
    check("raw_p1_rdata", p1_rdata, 8'hA5);
    check("raw_dbg2", mem_debugaccess, 0);
    next;
    drive(1, 0, 10'h010, 0, 1, 0, 10'h020, 0);
    freeze = 1;
    repeat (3) begin
      @(negedge clk);
      check("frz_gnt", {p0_gnt, p1_gnt}, 0);
      check("frz_cs", mem_chipselect, 0);
      check("frz_addr", mem_address, 0);
      next;
    end
    freeze = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("resume_p1_gnt", p1_gnt, i < 3);
      check("resume_p0_gnt", p0_gnt, i == 3);
      next;
    end
    freeze = 1;
    @(negedge clk);
    check("frz_rv_kept", p0_rvalid, 1);
    check("frz_rv_data", p0_rdata, f(10'h010));
    check("frz_gnt2", {p0_gnt, p1_gnt}, 0);
    next;
    freeze = 0;
    drive(1, 0, 10'h010, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("prerst_gnt", p0_gnt, 1);
    next;
    reset_n = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("rst_drop_rv", p0_rvalid, 0);
    check("rst_drop_rdata", p0_rdata, 0);
    next;
    drive(1, 0, 10'h010, 0, 1, 0, 10'h020, 0);
    @(negedge clk);
    check("rst_hold_gnt", {p0_gnt, p1_gnt}, 0);
    next;
    reset_n = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("post_outs", {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_chipselect, mem_write, mem_debugaccess}, 0);
    check("post_data", {p0_rdata, p1_rdata, mem_writedata, mem_address}, 0);
    check("post_clken", mem_clken, 1);
    next;
    drive(1, 0, 10'h010, 0, 1, 0, 10'h020, 0);
    @(negedge clk);
    check("post_tie_p0", {p0_gnt, p1_gnt}, 2'b10);
    next;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
